// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding constants: operation codes, opcode fields and immediate limits
// used by both the encoder and the single-cycle control decoder.
package legv8_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_ORR  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_CBZ  = 4'd6,
        OP_B    = 4'd7,
        OP_LDUR = 4'd8,
        OP_STUR = 4'd9,
        OP_MOVZ = 4'd10
    } op_e;

    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

    localparam int IMM_I_MAX  = 4095;
    localparam int IMM_D_MIN  = -256;
    localparam int IMM_D_MAX  = 255;
    localparam int IMM_CB_MIN = -(1 << 18);
    localparam int IMM_CB_MAX = (1 << 18) - 1;
    localparam int IMM_B_MIN  = -(1 << 25);
    localparam int IMM_B_MAX  = (1 << 25) - 1;
    localparam int IMM_IM_MAX = 65535;

endpackage

// File: rtl/legv8_word_pack.sv
// Combinational LEGv8 field packer: builds the 32-bit word for one request and
// flags whether the operation and its immediate are encodable.
module legv8_word_pack
    import legv8_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [31:0] imm,
    input  logic [1:0]  hw,
    output logic [31:0] word,
    output logic        legal
);

    logic signed [31:0] simm;

    assign simm = signed'(imm);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (op_e'(op))
            OP_AND: begin word = {OPC_AND, rm, 6'd0, rn, rd}; legal = 1'b1; end
            OP_ORR: begin word = {OPC_ORR, rm, 6'd0, rn, rd}; legal = 1'b1; end
            OP_ADD: begin word = {OPC_ADD, rm, 6'd0, rn, rd}; legal = 1'b1; end
            OP_SUB: begin word = {OPC_SUB, rm, 6'd0, rn, rd}; legal = 1'b1; end
            OP_ADDI: begin
                word  = {OPC_ADDI, imm[11:0], rn, rd};
                legal = (simm >= 0) && (simm <= IMM_I_MAX);
            end
            OP_SUBI: begin
                word  = {OPC_SUBI, imm[11:0], rn, rd};
                legal = (simm >= 0) && (simm <= IMM_I_MAX);
            end
            OP_LDUR: begin
                word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
                legal = (simm >= IMM_D_MIN) && (simm <= IMM_D_MAX);
            end
            OP_STUR: begin
                word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
                legal = (simm >= IMM_D_MIN) && (simm <= IMM_D_MAX);
            end
            OP_CBZ: begin
                word  = {OPC_CBZ, imm[18:0], rd};
                legal = (simm >= IMM_CB_MIN) && (simm <= IMM_CB_MAX);
            end
            OP_B: begin
                word  = {OPC_B, imm[25:0]};
                legal = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX);
            end
            OP_MOVZ: begin
                word  = {OPC_MOVZ, hw, imm[15:0], rd};
                legal = (simm >= 0) && (simm <= IMM_IM_MAX);
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/legv8_inst_encoder.sv
// LEGv8 instruction encoder: accepts field-level requests, packs legal ones into
// address-tagged words and streams them through a small FIFO; counts rejects.
module legv8_inst_encoder
    import legv8_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          DEPTH     = 2
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [31:0] imm,
    input  logic [1:0]  hw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_addr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   mem_word [DEPTH];
    logic [63:0]   mem_addr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [63:0]   addr_cnt;

    logic [31:0] packed_word;
    logic        packed_legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        reject;

    legv8_word_pack u_word_pack (
        .op    (op),
        .rd    (rd),
        .rn    (rn),
        .rm    (rm),
        .imm   (imm),
        .hw    (hw),
        .word  (packed_word),
        .legal (packed_legal)
    );

    assign in_ready   = (count < FULL_CNT) & ~clr;
    assign out_valid  = (count != '0);
    assign accept     = in_valid & in_ready;
    assign push       = accept & packed_legal;
    assign reject     = accept & ~packed_legal;
    assign pop        = out_valid & out_ready & ~clr;
    // Head is forced to zero when empty so a flushed word never shows through.
    assign instr      = out_valid ? mem_word[rd_ptr] : '0;
    assign instr_addr = out_valid ? mem_addr[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_word[wr_ptr] <= packed_word;
            mem_addr[wr_ptr] <= addr_cnt;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_cnt <= BASE_ADDR;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_cnt <= BASE_ADDR;
            err      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                addr_cnt <= addr_cnt + 64'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            err <= reject;
            if (reject && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_legv8_inst_encoder.sv
// Bench for legv8_inst_encoder: directed encodings, reject/stall/flush/reset
// sequences, then random traffic against an arithmetic reference model.
module tb_legv8_inst_encoder;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [31:0] imm;
    logic [1:0]  hw;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [63:0] instr_addr;
    logic        err;
    logic [7:0]  err_cnt;

    int pass_cnt = 0;
    int total    = 0;

    always #5 CLK = ~CLK;

    legv8_inst_encoder #(.BASE_ADDR(64'h0), .DEPTH(2)) dut (
        .CLK        (CLK),
        .resetl     (resetl),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rd         (rd),
        .rn         (rn),
        .rm         (rm),
        .imm        (imm),
        .hw         (hw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .instr_addr (instr_addr),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int o, input int d, input int n, input int m,
                           input int i, input int h);
        op  = 4'(o);
        rd  = 5'(d);
        rn  = 5'(n);
        rm  = 5'(m);
        imm = 32'(i);
        hw  = 2'(h);
    endtask

    // Reference encoding from the instruction formats, using plain arithmetic.
    function automatic longint wrapm(input longint v, input longint m);
        return ((v % m) + m) % m;
    endfunction

    function automatic bit ref_legal(input int o, input longint i);
        case (o)
            0, 1, 2, 3: return 1;
            4, 5:       return (i >= 0) && (i <= 4095);
            8, 9:       return (i >= -256) && (i <= 255);
            6:          return (i >= -(longint'(1) << 18)) && (i < (longint'(1) << 18));
            7:          return (i >= -(longint'(1) << 25)) && (i < (longint'(1) << 25));
            10:         return (i >= 0) && (i <= 65535);
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int o, input int d, input int n,
                                             input int m, input longint i, input int h);
        longint w;
        case (o)
            0:  w = 'b10001010000 * 2**21 + m * 2**16 + n * 32 + d;
            1:  w = 'b10101010000 * 2**21 + m * 2**16 + n * 32 + d;
            2:  w = 'b10001011000 * 2**21 + m * 2**16 + n * 32 + d;
            3:  w = 'b11001011000 * 2**21 + m * 2**16 + n * 32 + d;
            4:  w = 'b1001000100 * 2**22 + i * 1024 + n * 32 + d;
            5:  w = 'b1101000100 * 2**22 + i * 1024 + n * 32 + d;
            8:  w = 'b11111000010 * 2**21 + wrapm(i, 512) * 4096 + n * 32 + d;
            9:  w = 'b11111000000 * 2**21 + wrapm(i, 512) * 4096 + n * 32 + d;
            6:  w = 'b10110100 * 2**24 + wrapm(i, 2**19) * 32 + d;
            7:  w = 'b000101 * 2**26 + wrapm(i, 2**26);
            10: w = 'b110100101 * 2**23 + h * 2**21 + i * 32 + d;
            default: w = 0;
        endcase
        return 32'(w);
    endfunction

    int imm_pool [20] = '{0, 1, -1, 255, 256, -256, -257, 4095, 4096, 65535, 65536,
                          262143, 262144, -262144, -262145, 33554431, 33554432,
                          -33554432, -33554433, 12};

    logic [31:0] exp_q_word [$];
    logic [63:0] exp_q_addr [$];
    logic [63:0] m_addr;
    logic        m_err;
    int          m_err_cnt;

    initial begin
        resetl = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_req(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_addr", instr_addr, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        resetl = 1'b1;
        tick();

        // Directed encodings; out_ready=1 so each word drains one cycle later.
        set_req(2, 3, 1, 2, 0, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_instr", instr, 32'h8B020023);
        chk("add_addr", instr_addr, 0);
        tick();
        set_req(4, 9, 31, 0, 1, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("addi_instr", instr, 32'h910007E9);
        chk("addi_addr", instr_addr, 4);
        tick();
        set_req(7, 0, 0, 0, -1, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("b_instr", instr, 32'h17FFFFFF);
        chk("b_addr", instr_addr, 8);
        tick();
        set_req(10, 5, 0, 0, 32'hBEEF, 1); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("movz_instr", instr, 32'hD2B7DDE5);
        chk("movz_addr", instr_addr, 12);
        tick();
        chk("drained", out_valid, 0);

        set_req(8, 1, 2, 0, 300, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("ldur_bad_valid", out_valid, 0);
        chk("ldur_bad_err", err, 1);
        chk("ldur_bad_cnt", err_cnt, 1);
        tick();
        chk("err_one_cycle", err, 0);
        set_req(8, 1, 2, 0, -8, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("ldur_instr", instr, ref_word(8, 1, 2, 0, -8, 0));
        chk("ldur_addr", instr_addr, 16);
        tick();
        set_req(12, 0, 0, 0, 0, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("illegal_op_err", err, 1);
        chk("illegal_op_cnt", err_cnt, 2);
        chk("illegal_op_valid", out_valid, 0);
        tick();

        // Stall: three back-to-back requests with the consumer blocked.
        out_ready = 1'b0;
        set_req(0, 1, 2, 3, 0, 0); in_valid = 1'b1; tick();
        chk("stall1_ready", in_ready, 1);
        chk("stall1_addr", instr_addr, 20);
        set_req(1, 4, 5, 6, 0, 0); tick();
        chk("stall2_ready", in_ready, 0);
        set_req(3, 7, 8, 9, 0, 0); tick();
        chk("stall3_ready", in_ready, 0);
        chk("stall_hold_instr", instr, ref_word(0, 1, 2, 3, 0, 0));
        chk("stall_hold_addr", instr_addr, 20);
        out_ready = 1'b1; tick();
        chk("rel1_addr", instr_addr, 24);
        chk("rel1_instr", instr, ref_word(1, 4, 5, 6, 0, 0));
        tick(); in_valid = 1'b0;
        chk("rel2_addr", instr_addr, 28);
        chk("rel2_instr", instr, ref_word(3, 7, 8, 9, 0, 0));
        tick();
        chk("rel_drained", out_valid, 0);

        // Flush with two words buffered.
        out_ready = 1'b0;
        set_req(2, 1, 1, 1, 0, 0); in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
        chk("pre_clr_addr", instr_addr, 32);
        clr = 1'b1; #1;
        chk("clr_blocks_ready", in_ready, 0);
        tick(); clr = 1'b0; #1;
        chk("clr_valid", out_valid, 0);
        chk("clr_keeps_cnt", err_cnt, 2);
        chk("clr_ready", in_ready, 1);
        out_ready = 1'b1;
        set_req(2, 3, 1, 2, 0, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("post_clr_addr", instr_addr, 0);

        // Asynchronous reset with a word buffered.
        out_ready = 1'b0;
        set_req(2, 3, 1, 2, 0, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        #2 resetl = 1'b0; #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_cnt", err_cnt, 0);
        tick(); resetl = 1'b1; out_ready = 1'b1; tick();

        // Random traffic against the reference model.
        m_addr = 0; m_err = 0; m_err_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int o, d, n, m, h;
            longint iv;
            bit exp_ready, acc;
            o  = $urandom_range(0, 15);
            d  = $urandom_range(0, 31);
            n  = $urandom_range(0, 31);
            m  = $urandom_range(0, 31);
            h  = $urandom_range(0, 3);
            iv = ($urandom_range(0, 3) == 0) ? longint'($signed(16'($urandom)))
                                             : imm_pool[$urandom_range(0, 19)];
            set_req(o, d, n, m, int'(iv), h);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = (exp_q_word.size() < 2);
            chk("rnd_in_ready", in_ready, exp_ready);
            chk("rnd_out_valid", out_valid, exp_q_word.size() != 0);
            if (exp_q_word.size() != 0) begin
                chk("rnd_instr", instr, exp_q_word[0]);
                chk("rnd_addr", instr_addr, exp_q_addr[0]);
            end
            acc = in_valid && exp_ready;
            if (out_ready && exp_q_word.size() != 0) begin
                void'(exp_q_word.pop_front());
                void'(exp_q_addr.pop_front());
            end
            m_err = acc && !ref_legal(o, iv);
            if (m_err && m_err_cnt < 255) m_err_cnt++;
            if (acc && ref_legal(o, iv)) begin
                exp_q_word.push_back(ref_word(o, d, n, m, iv, h));
                exp_q_addr.push_back(m_addr);
                m_addr = m_addr + 4;
            end
            @(posedge CLK); #1;
            chk("rnd_err", err, m_err);
            chk("rnd_err_cnt", err_cnt, m_err_cnt);
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/legv8_inst_encoder.md
Name: legv8_inst_encoder

Overview:
- Converts field-level instruction requests (operation, registers, immediate) into 32-bit LEGv8 machine words.
- Covers exactly the subset the single-cycle control decoder recognises: AND, ORR, ADD, SUB, ADDI, SUBI, CBZ, B, LDUR, STUR, MOVZ.
- Each encoded word is tagged with a sequential instruction-memory byte address and streamed over a valid/ready port to the instruction-memory preload path.
- It is the encoding counterpart of the opcode decoder and is used by self-test program loaders and bench stimulus.

Parameters:
BASE_ADDR, 64'h0, address assigned to the first word after reset or clr
DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
CLK  in  1  clock, rising edge
resetl  in  1  asynchronous active-low reset
clr  in  1  synchronous flush: empty buffer, reload address counter
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
op  in  4  0 AND, 1 ORR, 2 ADD, 3 SUB, 4 ADDI, 5 SUBI, 6 CBZ, 7 B, 8 LDUR, 9 STUR, 10 MOVZ; 11-15 illegal
rd  in  5  Rd/Rt
rn  in  5  Rn
rm  in  5  Rm
imm  in  32  immediate, signed two's complement
hw  in  2  MOVZ shift field
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts when out_valid&out_ready
instr  out  32  encoded word
instr_addr  out  64  byte address of instr
err  out  1  one-cycle pulse: last accepted request rejected
err_cnt  out  8  saturating count of rejected requests

Behaviour:
- Reset (resetl=0, async): buffer empty, out_valid=0, instr=0, instr_addr=0, err=0, err_cnt=0, address counter=BASE_ADDR.
- in_ready = (buffer count < DEPTH) & ~clr. No same-cycle pop-through when full.
- Formats (bit 31 first):
  - R (AND 10001010000, ORR 10101010000, ADD 10001011000, SUB 11001011000): opcode[31:21], rm[20:16], shamt[15:10]=0, rn[9:5], rd[4:0].
  - I (ADDI 1001000100, SUBI 1101000100): [31:22], imm[11:0] at [21:10], rn, rd.
  - D (LDUR 11111000010, STUR 11111000000): [31:21], imm[8:0] at [20:12], op2[11:10]=00, rn, rd.
  - CB (CBZ 10110100): [31:24], imm[18:0] at [23:5], rd at [4:0].
  - B (000101): [31:26], imm[25:0].
  - IM (MOVZ 110100101): [31:23], hw[22:21], imm[15:0] at [20:5], rd.
- Legality checks on accept:
  - ADDI/SUBI: 0<=imm<=4095.
  - LDUR/STUR: -256<=imm<=255.
  - CBZ: -2^18<=imm<2^18.
  - B: -2^25<=imm<2^25.
  - MOVZ: 0<=imm<=65535.
  - R-type: imm ignored.
  - op 11-15: illegal.
- Legal accepted request: word pushed into the buffer with the current counter value; counter += 4 (64-bit wrap). Word visible at the buffer head the next cycle (1-cycle latency when the buffer was empty).
- Rejected request: consumed (handshake completes), nothing pushed, counter unchanged. err=1 the following cycle only; err_cnt increments, saturating at 255.
- Output: instr/instr_addr are the buffer head and hold stable while out_valid&~out_ready. Push and pop in the same cycle are both honoured when not full.
- clr: has priority over everything. Next cycle: buffer empty, out_valid=0, counter=BASE_ADDR. err_cnt is kept, err cleared.
- resetl asserted mid-transfer: all state cleared immediately; no partial word is emitted.

Decomposition:
- Shared package legv8_pkg:
  - op enum;
  - 11/10/9/8/6-bit opcode constants;
  - immediate range limits, shared with the control decoder's patterns.
- Sub-module legv8_word_pack: purely combinational format/range encoder producing word and legal.
- Top level holds the handshake, address counter, FIFO and error logic.

Test Plan:
- ADD rd=3,rn=1,rm=2 after reset -> next cycle out_valid=1, instr=0x8B020023, instr_addr=0.
- ADDI rd=9,rn=31,imm=1 -> instr=0x910007E9.
- B imm=-1 -> instr=0x17FFFFFF. MOVZ rd=5,imm=0xBEEF,hw=1 -> instr=0xD2B7DDE5.
- LDUR imm=300 -> no output, err pulse one cycle, err_cnt=1. Following legal op still gets the previous address+4 sequence unbroken.
- out_ready=0, three back-to-back legal requests -> in_ready drops after 2. Release: addrs 0,4,8 in order, instr stable while stalled.
- Buffer holding 2 words, pulse clr (or resetl low) -> out_valid=0 next cycle (immediately for reset). Next word gets addr BASE_ADDR.
